// File: rtl/gpio_reg_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_reg_arbiter
//
// Round-robin arbiter that shares the single register-bus port of one GPIO
// peripheral among NumReq register-bus requesters. One transaction is in
// flight at a time. The granted request is forwarded live to the GPIO. The
// GPIO response is routed back only to the requester that owns the grant.
//
// Optional feature macro: GPIO_REG_ARB_TIMEOUT_EN
//   Defined   : a BUSY transfer that has not seen ready after TimeoutCycles
//               BUSY cycles is aborted with an error response and a one-cycle
//               timeout_o pulse.
//   Undefined : BUSY waits indefinitely for ready and timeout_o is tied low.
//
// Parameters
//   NumReq        number of requesters (>= 1)
//   TimeoutCycles BUSY cycles before abort (>= 1, timeout build only)
//   reg_req_t     request struct  {valid, write, addr, wdata, wstrb}
//   reg_rsp_t     response struct {ready, rdata, error}
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   rst_ni     synchronous active-low reset
//   req_i      requests from the requesters (NumReq entries)
//   rsp_o      responses to the requesters (NumReq entries)
//   req_o      request to the GPIO register port
//   rsp_i      response from the GPIO register port
//   busy_o     high while a transfer is in progress
//   grant_o    index of the current or last granted requester
//   timeout_o  one-cycle pulse when a transfer is aborted
// ---------------------------------------------------------------------------

package gpio_reg_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

endpackage

module gpio_reg_arbiter #(
    parameter int unsigned NumReq        = 32'd2,
    parameter int unsigned TimeoutCycles = 32'd16,
    parameter type         reg_req_t     = gpio_reg_arbiter_pkg::reg_req_t,
    parameter type         reg_rsp_t     = gpio_reg_arbiter_pkg::reg_rsp_t,
    localparam int unsigned IdxW         = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  reg_req_t [NumReq-1:0] req_i,
    output reg_rsp_t [NumReq-1:0] rsp_o,
    output reg_req_t              req_o,
    input  reg_rsp_t              rsp_i,
    output logic                  busy_o,
    output logic [IdxW-1:0]       grant_o,
    output logic                  timeout_o
);

    // Reject illegal configurations at elaboration time.
    if (NumReq < 32'd1) begin : g_num_req_check
        $error("gpio_reg_arbiter: NumReq must be at least 1");
    end
    if (TimeoutCycles < 32'd1) begin : g_timeout_check
        $error("gpio_reg_arbiter: TimeoutCycles must be at least 1");
    end

    localparam int unsigned ReqW = $bits(reg_req_t);
    localparam int unsigned RspW = $bits(reg_rsp_t);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] ptr_q, ptr_d;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] grant_next;
    logic            abort;
    logic            finish;
    reg_rsp_t        abort_rsp;

    // Pointer value after the current owner: the requester just above it, wrapping.
    assign grant_next = (grant_q == IdxW'(NumReq - 32'd1)) ? {IdxW{1'b0}}
                                                           : grant_q + IdxW'(1'b1);

`ifdef GPIO_REG_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 32'd1) ? $clog2(TimeoutCycles) : 32'd1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Abort fires in the TimeoutCycles-th BUSY cycle; a same-cycle ready wins.
    assign abort = (state_q == StBusy) && !rsp_i.ready &&
                   (cnt_q == CntW'(TimeoutCycles - 32'd1));

    // Wait counter: held at zero while idle so every grant starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = {CntW{1'b0}};
        end else if (!rsp_i.ready) begin
            cnt_d = cnt_q + CntW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= {CntW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Round-robin pick: first valid requester at or above ptr_q, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NumReq);
            if (!pick_valid && req_i[cand].valid) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end else begin
                pick_valid = pick_valid;
            end
        end
    end

    // A BUSY transfer ends on ready, on abort, or when the owner withdraws.
    assign finish = rsp_i.ready || abort || !req_i[grant_q].valid;

    // Next-state logic for the IDLE/BUSY controller.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StBusy;
                    grant_d = pick_idx;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (finish) begin
                    state_d = StIdle;
                    ptr_d   = grant_next;
                end else begin
                    state_d = StBusy;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= {IdxW{1'b0}};
            ptr_q   <= {IdxW{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Error response returned to the owner when a stalled transfer is aborted.
    always_comb begin
        abort_rsp       = {RspW{1'b0}};
        abort_rsp.ready = 1'b1;
        abort_rsp.error = 1'b1;
    end

    // Bus forwarding. Outputs are forced quiet while reset is asserted so that
    // nothing leaks between the reset request and the reset edge.
    always_comb begin
        req_o = {ReqW{1'b0}};
        rsp_o = {(NumReq * RspW){1'b0}};
        if (rst_ni && (state_q == StBusy)) begin
            req_o          = req_i[grant_q];
            rsp_o[grant_q] = rsp_i;
            if (abort) begin
                req_o.valid    = 1'b0;
                rsp_o[grant_q] = abort_rsp;
            end else begin
                req_o.valid    = req_i[grant_q].valid;
            end
        end else begin
            req_o = {ReqW{1'b0}};
        end
    end

    assign busy_o    = rst_ni && (state_q == StBusy);
    assign grant_o   = grant_q;
    assign timeout_o = rst_ni && abort;

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_reg_arbiter
//
// Directed bench for gpio_reg_arbiter with three requesters. A behavioural
// model (owner / last-served / cycles-waited bookkeeping) predicts every
// output on every falling clock edge; directed scenarios add hand-computed
// literal checks. The timeout scenario is built when GPIO_REG_ARB_TIMEOUT_EN
// is defined, the unbounded stall scenario otherwise.
// ---------------------------------------------------------------------------
module tb_gpio_reg_arbiter;
    import gpio_reg_arbiter_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 4;
    localparam int unsigned IW = 2;

    logic             clk    = 1'b0;
    logic             rst_ni = 1'b0;
    reg_req_t [N-1:0] req_i  = '0;
    reg_rsp_t [N-1:0] rsp_o;
    reg_req_t         req_o;
    reg_rsp_t         rsp_i  = '0;
    logic             busy_o;
    logic [IW-1:0]    grant_o;
    logic             timeout_o;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: is a transfer open, who owns it, who was served last,
    // and how many BUSY cycles the owner has waited without ready.
    bit m_busy   = 1'b0;
    int m_who    = 0;
    int m_last   = N - 1;
    int m_waited = 0;

    int   grant_log[$];
    int   to_pulses = 0;
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;

    gpio_reg_arbiter #(
        .NumReq       (N),
        .TimeoutCycles(TO)
    ) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .rsp_o    (rsp_o),
        .req_o    (req_o),
        .rsp_i    (rsp_i),
        .busy_o   (busy_o),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model compare and update, once per cycle on the falling edge.
    always @(negedge clk) begin
        reg_req_t         e_req;
        reg_rsp_t [N-1:0] e_rsp;
        logic             e_busy;
        logic             e_to;
        logic [IW-1:0]    e_grant;
        bit               found;
        int               c;
        e_req   = '0;
        e_rsp   = '0;
        e_busy  = 1'b0;
        e_to    = 1'b0;
        e_grant = m_who[IW-1:0];
        if (rst_ni && m_busy) begin
            e_busy       = 1'b1;
            e_req        = req_i[m_who];
            e_rsp[m_who] = rsp_i;
`ifdef GPIO_REG_ARB_TIMEOUT_EN
            if (!rsp_i.ready && (m_waited + 1 == TO)) begin
                e_to         = 1'b1;
                e_req.valid  = 1'b0;
                e_rsp[m_who] = '{ready: 1'b1, rdata: 32'h0, error: 1'b1};
            end
`endif
        end
        chk("model_req_o",     128'(req_o),     128'(e_req));
        chk("model_rsp_o",     128'(rsp_o),     128'(e_rsp));
        chk("model_busy_o",    128'(busy_o),    128'(e_busy));
        chk("model_grant_o",   128'(grant_o),   128'(e_grant));
        chk("model_timeout_o", 128'(timeout_o), 128'(e_to));

        if (busy_o === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(int'(grant_o));
        if (timeout_o === 1'b1) to_pulses++;
        prev_busy = busy_o;

        if (!rst_ni) begin
            m_busy = 1'b0; m_who = 0; m_last = N - 1; m_waited = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req_i[c].valid) begin
                    found = 1'b1; m_busy = 1'b1; m_who = c; m_waited = 0;
                end
            end
        end else if (rsp_i.ready || e_to || !req_i[m_who].valid) begin
            m_busy = 1'b0;
            m_last = m_who;
        end else begin
            m_waited++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        req_i[k].valid = v;
        req_i[k].write = w;
        req_i[k].addr  = a;
        req_i[k].wdata = d;
        req_i[k].wstrb = 4'hF;
    endtask

    task automatic set_rsp(input logic rdy, input logic [31:0] rd);
        rsp_i.ready = rdy;
        rsp_i.rdata = rd;
        rsp_i.error = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i  = '0;
        rsp_i  = '0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        // Reset values.
        do_reset();
        chk("rst_busy",    128'(busy_o),    128'(0));
        chk("rst_grant",   128'(grant_o),   128'(0));
        chk("rst_timeout", 128'(timeout_o), 128'(0));
        chk("rst_req",     128'(req_o),     128'(0));

        // Single requester read, GPIO ready immediately.
        set_rsp(1'b1, 32'hA5);
        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("single_no_same_cycle", 128'(req_o.valid), 128'(0));
        tick();
        #1;
        chk("single_ready",  128'(rsp_o[0].ready), 128'(1));
        chk("single_rdata",  128'(rsp_o[0].rdata), 128'(32'hA5));
        chk("single_rsp1",   128'(rsp_o[1]),       128'(0));
        chk("single_fwd",    128'(req_o.valid),    128'(1));
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rsp(1'b0, 32'h0);
        #1;
        chk("single_idle", 128'(busy_o), 128'(0));

        // Contention between requesters 0 and 1, starting from reset.
        do_reset();
        grant_log.delete();
        set_rsp(1'b1, 32'h0);
        set_req(0, 1'b1, 1'b1, 32'h10, 32'h111);
        set_req(1, 1'b1, 1'b1, 32'h14, 32'h222);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("cont_grant", 128'(grant_o),     128'(i % 2));
            chk("cont_addr",  128'(req_o.addr),  (i % 2 == 1) ? 128'(32'h14) : 128'(32'h10));
            chk("cont_wdata", 128'(req_o.wdata), (i % 2 == 1) ? 128'(32'h222) : 128'(32'h111));
            tick();
            #1;
            chk("cont_gap", 128'(busy_o), 128'(0));
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("cont_log_len", 128'(grant_log.size()), 128'(4));
        if (grant_log.size() == 4) begin
            chk("cont_log0", 128'(grant_log[0]), 128'(0));
            chk("cont_log1", 128'(grant_log[1]), 128'(1));
            chk("cont_log2", 128'(grant_log[2]), 128'(0));
            chk("cont_log3", 128'(grant_log[3]), 128'(1));
        end

        // Round-robin wrap: serve 0 first so the pointer sits at 1.
        do_reset();
        set_rsp(1'b1, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        grant_log.delete();
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h28, 32'h0);
        tick();
        #1;
        chk("wrap_first",      128'(grant_o),    128'(2));
        chk("wrap_first_addr", 128'(req_o.addr), 128'(32'h28));
        tick();
        tick();
        #1;
        chk("wrap_second", 128'(grant_o), 128'(0));
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("wrap_log_len", 128'(grant_log.size()), 128'(2));

`ifndef GPIO_REG_ARB_TIMEOUT_EN
        // Stalled slave: five BUSY cycles without ready, completion on the sixth.
        set_rsp(1'b0, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'h30, 32'h333);
        tick();
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk("stall_busy",  128'(busy_o),          128'(1));
            chk("stall_addr",  128'(req_o.addr),      128'(32'h30));
            chk("stall_ready", 128'(rsp_o[1].ready),  128'(0));
            tick();
        end
        set_rsp(1'b1, 32'h5A);
        #1;
        chk("stall_done_ready", 128'(rsp_o[1].ready), 128'(1));
        chk("stall_done_rdata", 128'(rsp_o[1].rdata), 128'(32'h5A));
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rsp(1'b0, 32'h0);
        #1;
        chk("stall_idle",     128'(busy_o),    128'(0));
        chk("stall_no_pulse", 128'(to_pulses), 128'(0));
`else
        // Timeout: ready never arrives, abort lands on the fourth BUSY cycle.
        to_pulses = 0;
        set_rsp(1'b0, 32'hDEAD);
        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("to_wait_pulse", 128'(timeout_o), 128'(0));
            chk("to_wait_busy",  128'(busy_o),    128'(1));
            tick();
        end
        #1;
        chk("to_ready", 128'(rsp_o[0].ready), 128'(1));
        chk("to_error", 128'(rsp_o[0].error), 128'(1));
        chk("to_rdata", 128'(rsp_o[0].rdata), 128'(0));
        chk("to_pulse", 128'(timeout_o),      128'(1));
        chk("to_valid", 128'(req_o.valid),    128'(0));
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rsp(1'b0, 32'h0);
        #1;
        chk("to_idle", 128'(busy_o), 128'(0));
        tick();
        chk("to_pulse_count", 128'(to_pulses), 128'(1));
`endif

        // Reset in the middle of a stalled transfer.
        set_rsp(1'b0, 32'h77);
        set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        tick();
        #1;
        chk("mid_grant", 128'(grant_o),         128'(1));
        chk("mid_busy",  128'(busy_o),          128'(1));
        chk("mid_ready", 128'(rsp_o[1].ready),  128'(0));
        rst_ni = 1'b0;
        tick();
        chk("mid_rst_busy",  128'(busy_o),      128'(0));
        chk("mid_rst_valid", 128'(req_o.valid), 128'(0));
        chk("mid_rst_grant", 128'(grant_o),     128'(0));
        chk("mid_rst_rsp",   128'(rsp_o),       128'(0));
        rst_ni = 1'b1;
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rsp(1'b0, 32'h0);
        tick();

        // Withdrawal: requester 0 drops before ready, pointer still advances.
        set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
        tick();
        #1;
        chk("wd_busy", 128'(busy_o), 128'(1));
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        #1;
        chk("wd_idle", 128'(busy_o), 128'(0));
        set_rsp(1'b1, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h54, 32'h0);
        tick();
        #1;
        chk("wd_next_grant", 128'(grant_o), 128'(1));
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rsp(1'b0, 32'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
